// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, arbitrates redirects,
// runs the post-flush drain window and stall watchdog. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
   parameter int unsigned DRAIN_CYCLES  = 2,
   parameter int unsigned STALL_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        mispredict_i,
   input  logic [31:0] mispredict_target_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        mispredict_flush,
   output logic        stall_timeout,
   output logic        busy
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_mispredict_cnt
`endif
);

   typedef enum logic {IDLE, DRAIN} state_t;

   localparam logic [31:0] ERET       = 32'h0000000e;
   localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [15:0] TIMEOUT    = 16'(STALL_TIMEOUT);

   state_t      state;
   logic [3:0]  drain_cnt;
   logic [15:0] stall_cnt;
   logic        timeout_q;
   logic        pend;
   logic [31:0] pend_target;

   logic [5:0]  req_stall;
   logic        idle;
   logic        exc;
   logic        mp_req;
   logic [31:0] mp_target;
   logic        mp_hold;

   assign idle      = (state == IDLE);
   assign exc       = idle && (excepttype_i != 32'd0);
   // a held-off redirect survives even if EX drops the request meanwhile
   assign mp_req    = idle && (mispredict_i || pend);
   assign mp_target = mispredict_i ? mispredict_target_i : pend_target;
   assign mp_hold   = !exc && mp_req && stallreq_mem;

   always_comb begin
      req_stall = 6'b000000;
      if (stallreq_mem)
         req_stall = 6'b011111;
      else if (stallreq_ex)
         req_stall = 6'b001111;
      else if (stallreq_id)
         req_stall = 6'b000111;
      else if (stallreq_if)
         req_stall = 6'b000011;
   end

   always_comb begin
      stall            = 6'b000000;
      flush            = 1'b0;
      mispredict_flush = 1'b0;
      new_pc           = 32'd0;
      if (!rst) begin
         if (exc) begin
            flush  = 1'b1;
            new_pc = (excepttype_i == ERET) ? cp0_epc_i : EXC_VECTOR;
         end else if (mp_req && !stallreq_mem) begin
            mispredict_flush = 1'b1;
            new_pc           = mp_target;
         end else begin
            stall = req_stall;
         end
      end
   end

   assign busy          = !rst && (state == DRAIN);
   assign stall_timeout = !rst && timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         drain_cnt   <= 4'd0;
         pend        <= 1'b0;
         pend_target <= 32'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (flush) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            DRAIN: begin
               if (drain_cnt == 4'd0)
                  state <= IDLE;
               else
                  drain_cnt <= drain_cnt - 4'd1;
            end
         endcase
         if (flush || mispredict_flush) begin
            pend <= 1'b0;
         end else if (mp_hold) begin
            pend        <= 1'b1;
            pend_target <= mp_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 16'd0;
         timeout_q <= 1'b0;
      end else if (stall[0]) begin
         if (stall_cnt != TIMEOUT)
            stall_cnt <= stall_cnt + 16'd1;
         if (stall_cnt >= TIMEOUT - 16'd1)
            timeout_q <= 1'b1;
      end else begin
         stall_cnt <= 16'd0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles   <= 32'd0;
         perf_flush_cnt      <= 32'd0;
         perf_mispredict_cnt <= 32'd0;
      end else begin
         if (stall[0])
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         if (mispredict_flush)
            perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: cycle model compared every cycle plus literal checks.
// Watchdog threshold shortened to 4 cycles.
module tb_pipe_ctrl;

   localparam int DRAIN = 2;
   localparam int TO    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_if = 1'b0;
   logic        stallreq_id = 1'b0;
   logic        stallreq_ex = 1'b0;
   logic        stallreq_mem = 1'b0;
   logic [31:0] excepttype_i = 32'd0;
   logic [31:0] cp0_epc_i = 32'd0;
   logic        mispredict_i = 1'b0;
   logic [31:0] mispredict_target_i = 32'd0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mispredict_flush;
   logic        stall_timeout;
   logic        busy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_mispredict_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(
      .EXC_VECTOR(32'h00000020),
      .DRAIN_CYCLES(DRAIN),
      .STALL_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stallreq_if(stallreq_if),
      .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem),
      .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i),
      .mispredict_i(mispredict_i),
      .mispredict_target_i(mispredict_target_i),
      .stall(stall),
      .flush(flush),
      .new_pc(new_pc),
      .mispredict_flush(mispredict_flush),
      .stall_timeout(stall_timeout),
      .busy(busy)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_cnt(perf_flush_cnt),
      .perf_mispredict_cnt(perf_mispredict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // model state: busy cycles left, pending redirect, stall run length
   int          m_drain = 0;
   logic        m_pend = 1'b0;
   logic [31:0] m_tgt = 32'd0;
   int          m_run = 0;
   logic        m_to = 1'b0;

   function automatic void model_out(output logic [5:0] s, output logic f,
                                     output logic mf, output logic b,
                                     output logic [31:0] pc);
      int k;
      logic [3:0] req;
      s = 6'd0; f = 1'b0; mf = 1'b0; b = 1'b0; pc = 32'd0;
      if (!rst) begin
         b = (m_drain > 0);
         req = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
         k = -1;
         for (int i = 0; i < 4; i++)
            if (req[i]) k = i;
         if (!b && excepttype_i != 32'd0) begin
            f = 1'b1;
            pc = (excepttype_i == 32'h0000000e) ? cp0_epc_i : 32'h00000020;
         end else if (!b && (mispredict_i || m_pend) && !stallreq_mem) begin
            mf = 1'b1;
            pc = mispredict_i ? mispredict_target_i : m_tgt;
         end else if (k >= 0) begin
            s = 6'((1 << (k + 2)) - 1);
         end
      end
   endfunction

   always @(posedge clk) begin
      logic [5:0] es;
      logic ef, emf, eb;
      logic [31:0] epc;
      model_out(es, ef, emf, eb, epc);
      if (rst) begin
         m_drain <= 0; m_pend <= 1'b0; m_tgt <= 32'd0;
         m_run <= 0; m_to <= 1'b0;
      end else begin
         if (ef) m_drain <= DRAIN;
         else if (m_drain > 0) m_drain <= m_drain - 1;
         if (ef || emf) m_pend <= 1'b0;
         else if (!eb && (mispredict_i || m_pend) && stallreq_mem) begin
            m_pend <= 1'b1;
            m_tgt <= mispredict_i ? mispredict_target_i : m_tgt;
         end
         if (es[0]) begin
            if (m_run + 1 >= TO) m_to <= 1'b1;
            m_run <= (m_run < TO) ? m_run + 1 : m_run;
         end else begin
            m_run <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [5:0] es;
      logic ef, emf, eb;
      logic [31:0] epc;
      model_out(es, ef, emf, eb, epc);
      chk("m_stall", 32'(stall), 32'(es));
      chk("m_flush", 32'(flush), 32'(ef));
      chk("m_mpflush", 32'(mispredict_flush), 32'(emf));
      chk("m_busy", 32'(busy), 32'(eb));
      chk("m_timeout", 32'(stall_timeout), 32'(!rst && m_to));
      if (ef || emf) chk("m_new_pc", new_pc, epc);
   endtask

   // req = {mem, ex, id, if}
   task automatic drive(input logic r, input logic [3:0] req,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input logic mp, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      rst = r;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
      excepttype_i = exc;
      cp0_epc_i = epc;
      mispredict_i = mp;
      mispredict_target_i = tgt;
      #2;
      compare_model();
   endtask

   initial begin
      drive(1, 4'b0000, 0, 0, 0, 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush), 0);
      drive(1, 4'b0100, 32'h8, 0, 1, 32'h44);
      chk("rst_new_pc", new_pc, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(stall_timeout), 0);
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("idle_stall", 32'(stall), 0);

      repeat (3) begin
         drive(0, 4'b0100, 0, 0, 0, 0);
         chk("ex_stall", 32'(stall), 32'b001111);
         chk("ex_flush", 32'(flush), 0);
      end
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("ex_release", 32'(stall), 0);
      chk("ex_no_timeout", 32'(stall_timeout), 0);

      drive(0, 4'b1010, 0, 0, 0, 0);
      chk("id_mem_stall", 32'(stall), 32'b011111);

      drive(0, 4'b0000, 32'h8, 0, 0, 0);
      chk("exc_flush", 32'(flush), 1);
      chk("exc_pc", new_pc, 32'h20);
      chk("exc_stall", 32'(stall), 0);
      drive(0, 4'b0000, 32'hc, 0, 0, 0);
      chk("drain1_busy", 32'(busy), 1);
      chk("drain1_noflush", 32'(flush), 0);
      drive(0, 4'b0100, 32'hc, 0, 0, 0);
      chk("drain2_busy", 32'(busy), 1);
      chk("drain2_noflush", 32'(flush), 0);
      chk("drain2_stall", 32'(stall), 32'b001111);
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("drain_end", 32'(busy), 0);

      drive(0, 4'b0000, 32'he, 32'h1234, 0, 0);
      chk("eret_flush", 32'(flush), 1);
      chk("eret_pc", new_pc, 32'h1234);
      repeat (3) drive(0, 4'b0000, 0, 0, 0, 0);

      repeat (2) begin
         drive(0, 4'b1000, 0, 0, 1, 32'h400);
         chk("mp_hold_stall", 32'(stall), 32'b011111);
         chk("mp_hold_off", 32'(mispredict_flush), 0);
      end
      drive(0, 4'b0000, 0, 0, 1, 32'h400);
      chk("mp_fire", 32'(mispredict_flush), 1);
      chk("mp_pc", new_pc, 32'h400);
      chk("mp_noflush", 32'(flush), 0);
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("mp_done", 32'(mispredict_flush), 0);

      drive(0, 4'b0100, 0, 0, 1, 32'h88);
      chk("mp_over_ex", 32'(stall), 0);
      chk("mp_over_ex_f", 32'(mispredict_flush), 1);
      drive(0, 4'b0000, 32'h8, 0, 1, 32'h88);
      chk("exc_over_mp", 32'(mispredict_flush), 0);
      chk("exc_over_mp_pc", new_pc, 32'h20);
      drive(0, 4'b0000, 0, 0, 1, 32'h90);
      chk("drain_mp_ign", 32'(mispredict_flush), 0);
      drive(0, 4'b0000, 0, 0, 0, 0);
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("drain2_end", 32'(busy), 0);

      for (int i = 0; i < 4; i++) begin
         drive(0, 4'b0001, 0, 0, 0, 0);
         chk("if_stall", 32'(stall), 32'b000011);
         chk("wd_pre", 32'(stall_timeout), 0);
      end
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("wd_set", 32'(stall_timeout), 1);
      repeat (3) begin
         drive(0, 4'b0000, 0, 0, 0, 0);
         chk("wd_sticky", 32'(stall_timeout), 1);
      end

      drive(0, 4'b0000, 32'h4, 0, 0, 0);
      chk("exc4_flush", 32'(flush), 1);
      drive(1, 4'b0010, 0, 0, 0, 0);
      chk("rst_drain_busy", 32'(busy), 0);
      chk("rst_drain_stall", 32'(stall), 0);
      chk("rst_wd_clr", 32'(stall_timeout), 0);
      drive(0, 4'b0000, 0, 0, 0, 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_wd", 32'(stall_timeout), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Merges stall requests from IF/ID/EX/MEM into the 6-bit stall vector consumed by the PC register and the stage registers.
- Arbitrates the three redirect sources: exception/eret, branch mispredict and plain stalls.
- Drives flush and the redirect PC. Runs a post-flush drain window and a stall watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, target PC for every exception other than eret.
- DRAIN_CYCLES, 2, cycles after a flush during which new exception/mispredict inputs are ignored (range 1..15).
- STALL_TIMEOUT, 1023, consecutive stalled cycles before stall_timeout sets (range 1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  IF stage stall request (instruction memory wait)
- stallreq_id  in  1  ID stage stall request (load-use hazard)
- stallreq_ex  in  1  EX stage stall request (multi-cycle mul/div)
- stallreq_mem  in  1  MEM stage stall request (data memory wait)
- excepttype_i  in  32  exception code from MEM; 0 = none, 32'h0000000e = eret
- cp0_epc_i  in  32  EPC value used for eret
- mispredict_i  in  1  EX resolved branch disagrees with prediction
- mispredict_target_i  in  32  correct target on mispredict
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
- flush  out  1  clear all stage registers this cycle
- new_pc  out  32  redirect target, valid when flush=1
- mispredict_flush  out  1  clear IF/ID and ID/EX only, PC redirected via new_pc
- stall_timeout  out  1  sticky watchdog flag
- busy  out  1  1 while in DRAIN state

Behaviour:
- Reset: state IDLE, drain counter 0, stall counter 0. Outputs while rst=1: stall=0, flush=0, new_pc=0, mispredict_flush=0, stall_timeout=0, busy=0.
- Output timing: stall, flush, mispredict_flush and new_pc are combinational from the current inputs and state, with zero-cycle latency. This lets the PC register act on them at the same edge. State, counters and stall_timeout are registered.
- States: IDLE and DRAIN.
- IDLE, priority order, highest first:
  - excepttype_i != 0:
    - flush=1, stall=0.
    - new_pc = cp0_epc_i if excepttype_i == 32'h0000000e, otherwise EXC_VECTOR.
    - Next state DRAIN, counter loaded with DRAIN_CYCLES-1.
  - Otherwise, mispredict_i=1:
    - mispredict_flush=1, new_pc=mispredict_target_i, flush=0.
    - stall=0, overriding any stallreq. Exception: if stallreq_mem=1, then stall=6'b011111 and mispredict_flush is held off until MEM releases; the redirect is not lost.
    - No DRAIN entry on mispredict.
  - Otherwise, stall by the latest-stage requester:
    - mem → 6'b011111
    - ex → 6'b001111
    - id → 6'b000111
    - if → 6'b000011
    - none → 6'b000000
- DRAIN:
  - flush=0, mispredict_flush=0.
  - excepttype_i and mispredict_i are ignored.
  - Stall requests are handled as in IDLE.
  - busy=1. Counter decrements each cycle; at 0, next state IDLE.
- rst asserted in DRAIN: immediately IDLE; the next edge clears everything.
- Watchdog:
  - Stall counter increments each cycle with stall[0]=1 and clears on any cycle with stall[0]=0.
  - When the counter reaches STALL_TIMEOUT, stall_timeout sets and stays set until rst. The counter saturates.
  - Flush cycles clear the counter.
- Width rules: new_pc is 32 bits and never incremented. Counters are 4-bit (drain) and 16-bit (stall).

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with stall[0]=1), perf_flush_cnt[31:0] (exception flushes) and perf_mispredict_cnt[31:0] (mispredict flushes).
  - All three clear on rst and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then stallreq_ex=1 for 3 cycles → stall=6'b001111 for exactly those 3 cycles, then 6'b000000; flush=0 throughout.
- stallreq_id=1 and stallreq_mem=1 together → stall=6'b011111.
- excepttype_i=32'h00000008 one cycle → same cycle flush=1, new_pc=32'h00000020, stall=0. Then busy=1 for 2 cycles. A second excepttype_i=32'h0000000c during those 2 cycles → no flush.
- excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234 → flush=1, new_pc=32'h00001234.
- mispredict_i=1, target 32'h00000400, stallreq_mem=1 for 2 cycles → stall=6'b011111 and mispredict_flush=0 for those 2 cycles. When MEM releases: mispredict_flush=1, new_pc=32'h00000400.
- STALL_TIMEOUT=4: stallreq_if held 4 cycles → stall_timeout=1 after the 4th edge. Release the request → stall_timeout stays 1 until rst.
